mem_port_arbiter: RTL and testbench

- Sequences the single shared memory port of the RISC-V core between three requesters: 0 = data load/store, 1 = instruction fetch, 2 = auxiliary/debug.
- Drives the 2-bit select of the three-input n-bit port mux: 00/01/10 pick requester 0/1/2; 11 is idle and makes the mux output zero.
- Holds each grant for the whole multi-cycle memory transaction.
- Aborts a transaction with an error pulse if memory does not respond in time.

---
 rtl/mem_arb_pkg.sv | 40 ++++
 rtl/arb_priority_pick.sv | 28 ++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter: FSM states, mux select
// codes, requester indices and small index helpers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } arb_state_e;

    localparam logic [1:0] SEL_REQ0 = 2'b00;
    localparam logic [1:0] SEL_REQ1 = 2'b01;
    localparam logic [1:0] SEL_REQ2 = 2'b10;
    localparam logic [1:0] SEL_IDLE = 2'b11;

    localparam logic [1:0] REQ_DATA  = 2'd0;
    localparam logic [1:0] REQ_FETCH = 2'd1;
    localparam logic [1:0] REQ_AUX   = 2'd2;

    localparam int unsigned NUM_REQ = 3;

    function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            REQ_DATA:  oh = 3'b001;
            REQ_FETCH: oh = 3'b010;
            REQ_AUX:   oh = 3'b100;
            default:   oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Reduces a value in 0..5 modulo 3.
    function automatic logic [1:0] wrap3(input logic [2:0] v);
        logic [2:0] r;
        r = (v >= 3'd3) ? (v - 3'd3) : v;
        return r[1:0];
    endfunction

endpackage

// File: rtl/arb_priority_pick.sv
// Combinational circular priority picker over three requesters; the search begins
// at the start index and wraps 2 -> 0.
module arb_priority_pick
    import mem_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] start,
    output logic       valid,
    output logic [1:0] winner
);

    logic [1:0] idx;

    // Walk from the lowest priority upward so the highest-priority hit is written last.
    always_comb begin
        valid  = 1'b0;
        winner = REQ_DATA;
        idx    = REQ_DATA;
        for (int i = 2; i >= 0; i--) begin
            idx = wrap3({1'b0, start} + 3'(i));
            if (req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter for data, fetch and aux requesters. Fixed priority by
// default; define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = $clog2(TIMEOUT)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic [1:0] sel,
    output logic       mem_valid,
    input  logic       mem_ready,
    output logic [2:0] done,
    output logic       err,
    output logic       busy
);

    import mem_arb_pkg::*;

    arb_state_e state_q, state_d;
    logic [2:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic       mem_valid_q, mem_valid_d;
    logic [2:0] done_q, done_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       pick_valid;
    logic [1:0] pick_winner;
    logic [1:0] pick_start;
    logic       timed_out;

    arb_priority_pick u_pick (
        .req    (req),
        .start  (pick_start),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [1:0] ptr_q, ptr_d;

    assign pick_start = wrap3({1'b0, ptr_q} + 3'd1);

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && pick_valid) begin
            ptr_d = pick_winner;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= REQ_AUX;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign pick_start = REQ_DATA;
`endif

    assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        mem_valid_d = mem_valid_q;
        done_d      = 3'b000;
        err_d       = 1'b0;
        cnt_d       = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d     = ACCESS;
                    gnt_d       = idx_to_onehot(pick_winner);
                    sel_d       = pick_winner;
                    mem_valid_d = 1'b1;
                    cnt_d       = '0;
                end
            end
            ACCESS: begin
                // A response in the final cycle still wins over the timeout.
                if (mem_ready || timed_out) begin
                    state_d     = RESP;
                    done_d      = gnt_q;
                    err_d       = !mem_ready;
                    gnt_d       = 3'b000;
                    sel_d       = SEL_IDLE;
                    mem_valid_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = 3'b000;
                sel_d       = SEL_IDLE;
                mem_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            gnt_q       <= 3'b000;
            sel_q       <= SEL_IDLE;
            mem_valid_q <= 1'b0;
            done_q      <= 3'b000;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            mem_valid_q <= mem_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign mem_valid = mem_valid_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner sequences
// and randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 16;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       mem_valid;
    logic       mem_ready;
    logic [2:0] done;
    logic       err;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .done      (done),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Observed output bundle: {gnt, sel, mem_valid, done, err, busy}
    function automatic logic [10:0] mk(input logic [2:0] g, input logic [1:0] s,
                                       input logic v, input logic [2:0] d,
                                       input logic e, input logic b);
        return {g, s, v, d, e, b};
    endfunction

    function automatic logic [10:0] obs();
        return {gnt, sel, mem_valid, done, err, busy};
    endfunction

    localparam logic [10:0] IDLE_OUT = 11'b000_11_0_000_0_0;

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got gnt/sel/v/done/err/busy=%b want %b (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    int m_owner;   // requester currently holding the port, -1 if none
    int m_age;     // ACCESS cycles already waited
    bit m_resp;    // completion cycle pending
    int m_who;
    bit m_err;
    int m_ptr;

    task automatic model_reset();
        m_owner = -1;
        m_age   = 0;
        m_resp  = 0;
        m_who   = 0;
        m_err   = 0;
        m_ptr   = 2;
    endtask

    function automatic int model_pick(input logic [2:0] r);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= 3; k++) begin
            int i;
            i = (m_ptr + k) % 3;
            if (r[i]) return i;
        end
`else
        for (int i = 0; i < 3; i++) begin
            if (r[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic model_step(input logic [2:0] r, input logic rdy);
        if (m_owner >= 0) begin
            if (rdy || m_age == TIMEOUT - 1) begin
                m_who   = m_owner;
                m_err   = !rdy;
                m_resp  = 1;
                m_owner = -1;
            end else begin
                m_age++;
            end
        end else if (m_resp) begin
            m_resp = 0;
        end else if (r != 3'b000) begin
            m_owner = model_pick(r);
            m_ptr   = m_owner;
            m_age   = 0;
        end
    endtask

    function automatic logic [10:0] model_exp();
        logic [2:0] g;
        logic [1:0] s;
        logic [2:0] d;
        g = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
        s = (m_owner >= 0) ? 2'(m_owner) : 2'b11;
        d = m_resp ? 3'(1 << m_who) : 3'b000;
        return mk(g, s, m_owner >= 0, d, m_resp && m_err, (m_owner >= 0) || m_resp);
    endfunction

    // ---------------- helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        req       = 3'b000;
        mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    function automatic int oh_idx(input logic [2:0] v);
        case (v)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return -1;
        endcase
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]  req;
        logic        rdy;
        logic [10:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int served;
        int acc;
        int mv_cnt;
        bit got;
        int order[4];
        int exp_order[4];
        int pct[6];

        rst       = 1'b0;
        req       = 3'b000;
        mem_ready = 1'b0;
        model_reset();

        tbl[0]  = '{3'b001, 1'b0, mk(3'b001, 2'b00, 1, 3'b000, 0, 1), "single_grant"};
        tbl[1]  = '{3'b001, 1'b1, mk(3'b000, 2'b11, 0, 3'b001, 0, 1), "single_done"};
        tbl[2]  = '{3'b000, 1'b0, IDLE_OUT,                           "single_idle"};
        tbl[3]  = '{3'b010, 1'b0, mk(3'b010, 2'b01, 1, 3'b000, 0, 1), "drop_grant"};
        tbl[4]  = '{3'b100, 1'b0, mk(3'b010, 2'b01, 1, 3'b000, 0, 1), "drop_hold1"};
        tbl[5]  = '{3'b100, 1'b0, mk(3'b010, 2'b01, 1, 3'b000, 0, 1), "drop_hold2"};
        tbl[6]  = '{3'b100, 1'b1, mk(3'b000, 2'b11, 0, 3'b010, 0, 1), "drop_done"};
        tbl[7]  = '{3'b100, 1'b0, IDLE_OUT,                           "drop_idle"};
        tbl[8]  = '{3'b100, 1'b0, mk(3'b100, 2'b10, 1, 3'b000, 0, 1), "next_grant"};
        tbl[9]  = '{3'b000, 1'b1, mk(3'b000, 2'b11, 0, 3'b100, 0, 1), "next_done"};
        tbl[10] = '{3'b000, 1'b0, IDLE_OUT,                           "next_idle"};

        do_reset();
        #1;
        check("reset_state", obs(), IDLE_OUT);

        for (int i = 0; i < 11; i++) begin
            req       = tbl[i].req;
            mem_ready = tbl[i].rdy;
            @(posedge clk);
            #1;
            check(tbl[i].name, obs(), tbl[i].exp);
        end

        // Contention with all requesters held high.
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 2, 0};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        do_reset();
        req    = 3'b111;
        served = 0;
        acc    = 0;
        for (int c = 0; c < 200 && served < 4; c++) begin
            @(posedge clk);
            #1;
            acc = mem_valid ? acc + 1 : 0;
            if (done != 3'b000) begin
                order[served] = oh_idx(done);
                served++;
            end
            mem_ready = (acc == 3);
        end
        check_int("contend_count", served, 4);
        for (int i = 0; i < 4; i++) begin
            check_int($sformatf("contend_order%0d", i), (i < served) ? order[i] : -2,
                      exp_order[i]);
        end
        req       = 3'b000;
        mem_ready = 1'b0;

        // Timeout: memory never answers.
        do_reset();
        req    = 3'b010;
        mv_cnt = 0;
        got    = 0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(posedge clk);
            #1;
            if (mem_valid) mv_cnt++;
            if (done != 3'b000) begin
                got = 1;
                check("timeout_resp", obs(), mk(3'b000, 2'b11, 0, 3'b010, 1, 1));
            end
        end
        check_int("timeout_seen", got, 1);
        check_int("timeout_valid_cycles", mv_cnt, TIMEOUT);
        req = 3'b000;

        // Response on the last allowed cycle counts as success.
        do_reset();
        req = 3'b010;
        acc = 0;
        got = 0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(posedge clk);
            #1;
            if (mem_valid) acc++;
            if (done != 3'b000) begin
                got = 1;
                check("late_ready_resp", obs(), mk(3'b000, 2'b11, 0, 3'b010, 0, 1));
            end
            mem_ready = mem_valid && (acc == TIMEOUT);
        end
        check_int("late_ready_seen", got, 1);
        check_int("late_ready_cycles", acc, TIMEOUT);
        req       = 3'b000;
        mem_ready = 1'b0;

        // Asynchronous reset mid-transaction.
        do_reset();
        req = 3'b001;
        @(posedge clk);
        #1;
        check("async_pre_grant", obs(), mk(3'b001, 2'b00, 1, 3'b000, 0, 1));
        #3;
        rst = 1'b0;
        #1;
        check("async_reset_now", obs(), IDLE_OUT);
        @(negedge clk);
        rst       = 1'b1;
        req       = 3'b000;
        mem_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("async_no_done%0d", c), obs(), IDLE_OUT);
        end
        mem_ready = 1'b0;

        // Randomized traffic against the reference model.
        pct = '{50, 10, 3, 0, 30, 80};
        do_reset();
        for (int b = 0; b < 6; b++) begin
            for (int c = 0; c < 500; c++) begin
                req       = 3'($urandom_range(0, 7));
                mem_ready = ($urandom_range(0, 99) < pct[b]);
                model_step(req, mem_ready);
                @(posedge clk);
                #1;
                check("random", obs(), model_exp());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
